partition_merger_nway: RTL
==========================

Name: partition_merger_nway

Overview:
- Parametrised successor to the two-partition merger. Element-wise sums NUM_INPUTS feature-map partitions held in one single-read-port memory and writes the merged partition back through a write port.
- Adds an optional bias, an optional ReLU and saturation to DATA_WIDTH.
- Reads are pipelined: one read is issued per cycle and a parametrised read latency is tracked.
- Sits between the conv partition buffers and the next layer's input buffer. Started by run, completion reported by a merge_done pulse.

Parameters:
- DATA_WIDTH, 16, signed element width.
- ADDR_WIDTH, 16, memory address width.
- NUM_INPUTS, 4, number of partitions to sum (2..16).
- PARTITION_WIDTH, 8, columns per partition.
- PARTITION_HEIGHT, 8, rows per partition.
- READ_LATENCY, 2, cycles from read_address_out/read_en to valid data_in (1..4).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- run  in  1  start pulse, sampled only in IDLE.
- src_base_in  in  ADDR_WIDTH  address of element 0 of partition 0.
- dst_base_in  in  ADDR_WIDTH  write address of element 0 of the result.
- bias_in  in  DATA_WIDTH  signed bias added to every element.
- relu_en_in  in  1  clamp negative results to 0.
- data_in  in  DATA_WIDTH  signed read data.
- read_address_out  out  ADDR_WIDTH  read address.
- read_en_out  out  1  read request strobe.
- result_out  out  DATA_WIDTH  merged element, valid when we_out=1.
- write_address_out  out  ADDR_WIDTH  write address.
- we_out  out  1  write strobe, one cycle per element.
- busy_out  out  1  high outside IDLE.
- merge_done  out  1  one-cycle pulse after the last write.

Behaviour:
- Derived constant: PSIZE = PARTITION_WIDTH*PARTITION_HEIGHT.
- Address of partition k, element i: src_base + k*PSIZE + i.
- Write address of element i: dst_base + i. All address arithmetic is modulo 2^ADDR_WIDTH.
- Run latch: on a run accepted in IDLE, capture src_base_in, dst_base_in, bias_in and relu_en_in into registers. Ignore later changes to those inputs and any run asserted while busy.
- States:
  - IDLE: run goes to ISSUE; clear the element index, k and the accumulator (loaded with sign-extended bias).
  - ISSUE: for NUM_INPUTS cycles, read_en_out=1 with the address for the current k; k increments each cycle. After k=NUM_INPUTS-1, go to DRAIN.
  - DRAIN: hold READ_LATENCY cycles with read_en_out=0, then go to WRITE.
  - WRITE: we_out=1 for one cycle with result_out and write_address_out valid; advance the element index and reload the accumulator with bias. Last element goes to DONE, otherwise to ISSUE.
  - DONE: merge_done=1 for one cycle, then IDLE.
- Return tracking: a READ_LATENCY-deep valid shift register tracks issued reads. Add data_in to the accumulator in the cycle its valid bit emerges. No data_in is consumed in any other cycle.
- Accumulator width: DATA_WIDTH+$clog2(NUM_INPUTS+1), signed, so the sum cannot overflow.
- Output path, combinational from the accumulator:
  - ReLU first if enabled.
  - Then saturate to [-2^(DW-1), 2^(DW-1)-1].
- Throughput: NUM_INPUTS+READ_LATENCY+1 cycles per element.
  - Run accepted at cycle 0 gives the first we_out at cycle 1+NUM_INPUTS+READ_LATENCY.
  - merge_done comes 1 cycle after the last we_out.
- When not asserted, read_address_out, write_address_out and result_out drive 0.
- Reset values: all outputs 0, state IDLE, accumulator/index/k 0, valid pipe cleared.
- Reset mid-operation: abandon the operation with no further we_out and no merge_done. Data returning after reset is ignored because the valid pipe is cleared.
- Boundary conditions:
  - Element index wraps from PSIZE-1 only via DONE.
  - run held high through DONE restarts one cycle later from IDLE, with values re-captured.

Decomposition:
- Package merger_pkg:
  - state enum {IDLE, ISSUE, DRAIN, WRITE, DONE}.
  - Function sat_relu(acc, relu_en) returning DATA_WIDTH.
  - Function for accumulator width.
- Sub-module merge_accumulator:
  - Owns the valid shift register, the bias-loaded accumulator and the saturate/ReLU output.
  - Controlled by issue/clear strobes from the FSM in partition_merger_nway.

Test Plan:
- Basic sum: NUM_INPUTS=2, READ_LATENCY=2, 2x2, bias 0, partitions {1,2,3,4} and {10,20,30,40} -> writes 11,22,33,44 at dst_base..+3; 5 cycles per element; merge_done 1 cycle after the 4th write.
- Four-way with bias=-5, ReLU on, values {1,1,1,1} and {-3,0,0,0} per element -> outputs 0 and 0 (clamped -5+... cases); e.g. element sums 4-5=-1 -> 0, -3-5=-8 -> 0, element {10,10,10,10} -> 35.
- Saturation at DATA_WIDTH=16: four inputs of 30000 -> 32767; four of -30000 -> -32768.
- Latency sweep READ_LATENCY=1,3,4: memory model with matching latency -> identical results, per-element period NUM_INPUTS+L+1, no read issued in DRAIN.
- Control: run pulse while busy ignored; src_base_in changed mid-run has no effect; reset at the 3rd write -> no further we_out and no merge_done; a fresh run completes correctly.
- Address wrap: ADDR_WIDTH=8, src_base=0xF0, NUM_INPUTS=2, PSIZE=16 -> partition 1 reads 0x00..0x0F; writes go to dst_base modulo 256.

Source files
------------

// File: rtl/merger_pkg.sv
// Shared types and helpers for the N-way partition merger: FSM state encoding,
// accumulator sizing and the ReLU/saturation output stage.
package merger_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    // Working width for sat_relu; wide enough for any legal accumulator.
    localparam int SAT_W = 64;

    // Sum of num_inputs values plus a bias can never leave this width.
    function automatic int acc_width(input int data_width, input int num_inputs);
        return data_width + $clog2(num_inputs + 1);
    endfunction

    // ReLU (optional) then clamp to the signed data_width range; the caller keeps
    // the low data_width bits, which already hold the final value.
    function automatic logic signed [SAT_W-1:0] sat_relu(
        input logic signed [SAT_W-1:0] acc,
        input logic                    relu_en,
        input int                      data_width
    );
        logic signed [SAT_W-1:0] value;
        logic signed [SAT_W-1:0] max_val;
        logic signed [SAT_W-1:0] min_val;
        value   = acc;
        max_val = (64'sd1 <<< (data_width - 1)) - 64'sd1;
        min_val = -max_val - 64'sd1;
        if (relu_en && value[SAT_W-1]) begin
            value = '0;
        end
        if (value > max_val) begin
            value = max_val;
        end else if (value < min_val) begin
            value = min_val;
        end
        return value;
    endfunction

endpackage

// File: rtl/partition_merger_nway_if.sv
// Memory-side bus of the merger: one pipelined read port and one write port.
interface partition_merger_nway_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic        [ADDR_WIDTH-1:0] read_address_out;
    logic                         read_en_out;
    logic signed [DATA_WIDTH-1:0] data_in;
    logic signed [DATA_WIDTH-1:0] result_out;
    logic        [ADDR_WIDTH-1:0] write_address_out;
    logic                         we_out;

    modport master (
        output read_address_out,
        output read_en_out,
        input  data_in,
        output result_out,
        output write_address_out,
        output we_out
    );

    modport slave (
        input  read_address_out,
        input  read_en_out,
        output data_in,
        input  result_out,
        input  write_address_out,
        input  we_out
    );
endinterface

// File: rtl/merge_accumulator.sv
// Read-return tracking and bias-loaded accumulator for the N-way merger, with
// the combinational ReLU/saturation output stage.
module merge_accumulator
    import merger_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_INPUTS   = 4,
    parameter int READ_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         issue,
    input  logic                         clear,
    input  logic signed [DATA_WIDTH-1:0] bias,
    input  logic                         relu_en,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    output logic signed [DATA_WIDTH-1:0] result
);
    localparam int ACC_W = acc_width(DATA_WIDTH, NUM_INPUTS);

    logic        [READ_LATENCY-1:0] valid_pipe;
    logic signed [ACC_W-1:0]        acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_pipe <= '0;
            acc        <= '0;
        end else begin
            // NOTE: non-blocking so every stage shifts on the same edge; blocking
            // here would collapse the pipe into a single register.
            valid_pipe[0] <= issue;
            for (int i = 1; i < READ_LATENCY; i++) begin
                valid_pipe[i] <= valid_pipe[i-1];
            end
            if (clear) begin
                acc <= ACC_W'(bias);
            end else if (valid_pipe[READ_LATENCY-1]) begin
                acc <= acc + ACC_W'(data_in);
            end
        end
    end

    assign result = DATA_WIDTH'(sat_relu(SAT_W'(acc), relu_en, DATA_WIDTH));

endmodule

// File: rtl/partition_merger_nway.sv
// N-way partition merger: per element, reads NUM_INPUTS partitions back to back,
// waits out the read latency, then writes bias + sum (ReLU/saturated).
module partition_merger_nway
    import merger_pkg::*;
#(
    parameter int DATA_WIDTH       = 16,
    parameter int ADDR_WIDTH       = 16,
    parameter int NUM_INPUTS       = 4,
    parameter int PARTITION_WIDTH  = 8,
    parameter int PARTITION_HEIGHT = 8,
    parameter int READ_LATENCY     = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run,
    input  logic        [ADDR_WIDTH-1:0] src_base_in,
    input  logic        [ADDR_WIDTH-1:0] dst_base_in,
    input  logic signed [DATA_WIDTH-1:0] bias_in,
    input  logic                         relu_en_in,
    partition_merger_nway_if.master      bus,
    output logic                         busy_out,
    output logic                         merge_done
);
    localparam int PSIZE = PARTITION_WIDTH * PARTITION_HEIGHT;
    localparam int IDX_W = (PSIZE > 1) ? $clog2(PSIZE) : 1;
    localparam int K_W   = $clog2(NUM_INPUTS);
    localparam int D_W   = $clog2(READ_LATENCY + 1);

    state_t state;
    state_t state_next;

    logic        [ADDR_WIDTH-1:0] src_base_r;
    logic        [ADDR_WIDTH-1:0] dst_base_r;
    logic signed [DATA_WIDTH-1:0] bias_r;
    logic                         relu_en_r;
    logic        [IDX_W-1:0]      idx;
    logic        [K_W-1:0]        k;
    logic        [D_W-1:0]        drain_cnt;

    logic                         acc_issue;
    logic                         acc_clear;
    logic signed [DATA_WIDTH-1:0] acc_bias;
    logic signed [DATA_WIDTH-1:0] acc_result;

    logic last_k;
    logic last_drain;
    logic last_idx;

    assign last_k     = (k == K_W'(NUM_INPUTS - 1));
    assign last_drain = (drain_cnt == D_W'(READ_LATENCY - 1));
    assign last_idx   = (idx == IDX_W'(PSIZE - 1));

    // The first element's bias comes straight from the port as the run is taken.
    assign acc_bias = (state == IDLE) ? bias_in : bias_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_base_r <= '0;
            dst_base_r <= '0;
            bias_r     <= '0;
            relu_en_r  <= 1'b0;
            idx        <= '0;
            k          <= '0;
            drain_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        src_base_r <= src_base_in;
                        dst_base_r <= dst_base_in;
                        bias_r     <= bias_in;
                        relu_en_r  <= relu_en_in;
                        idx        <= '0;
                        k          <= '0;
                    end
                end
                ISSUE: begin
                    k         <= last_k ? '0 : k + 1'b1;
                    drain_cnt <= '0;
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 1'b1;
                end
                WRITE: begin
                    if (!last_idx) begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case
        // leaves one unassigned and infers a latch.
        state_next            = state;
        acc_issue             = 1'b0;
        acc_clear             = 1'b0;
        bus.read_en_out       = 1'b0;
        bus.read_address_out  = '0;
        bus.we_out            = 1'b0;
        bus.write_address_out = '0;
        bus.result_out        = '0;
        busy_out              = (state != IDLE);
        merge_done            = 1'b0;
        case (state)
            IDLE: begin
                if (run) begin
                    acc_clear  = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                acc_issue            = 1'b1;
                bus.read_en_out      = 1'b1;
                bus.read_address_out = src_base_r + ADDR_WIDTH'(int'(k) * PSIZE + int'(idx));
                if (last_k) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (last_drain) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                bus.we_out            = 1'b1;
                bus.write_address_out = dst_base_r + ADDR_WIDTH'(idx);
                bus.result_out        = acc_result;
                acc_clear             = 1'b1;
                state_next            = last_idx ? DONE : ISSUE;
            end
            DONE: begin
                merge_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    merge_accumulator #(
        .DATA_WIDTH  (DATA_WIDTH),
        .NUM_INPUTS  (NUM_INPUTS),
        .READ_LATENCY(READ_LATENCY)
    ) u_acc (
        .clk    (clk),
        .reset  (reset),
        .issue  (acc_issue),
        .clear  (acc_clear),
        .bias   (acc_bias),
        .relu_en(relu_en_r),
        .data_in(bus.data_in),
        .result (acc_result)
    );

endmodule
